onehot_serial_encoder: RTL and testbench
========================================

# onehot_serial_encoder

Parametrised, handshaked successor to the combinational octal-to-binary encoder. It accepts an N-bit request vector with any number of bits set. It then emits the binary index of every set bit, one index per accepted output beat, in a selectable priority order. It sits between multi-source request/interrupt vectors and downstream logic that consumes one binary index at a time.

## Interface
Parameters:
- N, 8, width of the input vector; any value ≥ 2.
- W, $clog2(N), index width (derived; do not override).
- MSB_FIRST, 0, order of emission: 0 emits the lowest set index first, 1 emits the highest set index first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  N  request vector.
- in_valid  input  1  `in` is valid this cycle.
- in_ready  output  1  block can accept a vector this cycle.
- out  output  W  binary index of the current pending bit.
- out_valid  output  1  `out` is valid.
- out_ready  input  1  consumer accepts the current beat.
- out_last  output  1  current beat is the final one for this vector.
- out_zero  output  1  captured vector was all zeros (beat carries no index).
- out_count  output  W+1  number of set bits in the captured vector, held for the whole burst.

## Operation
- State: IDLE, EMIT. The pending register is `pend[N-1:0]`.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: pend<=in; out_count<=popcount(in); zero flag<=(in==0); go to EMIT.
  - in_valid is ignored in every other state.
- EMIT:
  - in_ready=0, out_valid=1.
  - `out` = index of the first set bit of pend in MSB_FIRST order.
  - out_last=1 when pend has exactly one bit set, or when the zero flag is set.
  - out_zero=zero flag; `out`=0 when the zero flag is set.
  - On out_valid & out_ready: clear the emitted bit in pend. If out_last, go to IDLE and clear the zero flag.
- All-zero vector: exactly one beat with out=0, out_zero=1, out_last=1, out_count=0.
- out, out_last, out_zero and out_count must stay stable while out_valid=1 & out_ready=0.
- out, out_last and out_zero are decoded from registered state only. There is no combinational path from in/in_valid to any output, and none from out_ready to out_valid or out.
- out_count is registered at capture and is not decremented.
- Reset (asserted at any time, including mid-burst):
  - State=IDLE, pend=0, zero flag=0, out_count=0.
  - Outputs: out=0, out_valid=0, out_last=0, out_zero=0, in_ready=1.
  - The burst in progress is discarded; no further beats of it are emitted.

## Timing
- Capture handshake at edge k → out_valid=1 from cycle k+1 (one-cycle latency).
- With out_ready held high, a vector with P set bits (P≥1) gives P beats on consecutive cycles k+1…k+P. For a zero vector, P is taken as 1.
- The final beat is accepted at edge k+P, giving in_ready=1 in cycle k+P+1.
- Minimum period between accepted vectors: P+1 cycles. There is no overlap of capture and emission.
- Backpressure: each cycle with out_ready=0 adds exactly one cycle, and no beat is lost or duplicated.
- in_valid asserted while in_ready=0 has no effect. The source must hold the vector until in_ready is high.

## Test plan
- Reset, then N=8, MSB_FIRST=0, in=8'b1010_0100 with out_ready=1:
  - out sequence is 2, 5, 7 on three consecutive cycles.
  - out_last=1 only on 7; out_count=3 throughout.
  - in_ready returns to 1 on the cycle after the beat with index 7.
- Same vector with MSB_FIRST=1 → out sequence 7, 5, 2; out_last=1 only on 2.
- in=8'h00 → a single beat with out=0, out_zero=1, out_last=1, out_count=0, then IDLE.
- in=8'hFF with out_ready low for 3 cycles after the first beat:
  - out holds at 0 for 4 cycles.
  - Then 1…7 follow, 8 beats in total, out_count=8.
  - A second vector presented on in with in_valid=1 during the burst is ignored.
- in=8'b1000_0000 → single beat out=7, out_last=1, out_count=1.
- Reset asserted asynchronously after the 2nd beat of in=8'hF0:
  - All outputs immediately take reset values: out_valid=0, in_ready=1.
  - After release, in=8'b0000_0011 emits 0, 1 only, with no residual beats from 8'hF0.

Source files
------------

// File: rtl/onehot_serial_encoder.sv
// Serialises an N-bit request vector into a stream of binary indices, one per
// accepted output beat, lowest-first or highest-first depending on MSB_FIRST.
module onehot_serial_encoder #(
    parameter int N         = 8,
    parameter int W         = $clog2(N),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         out_zero,
    output logic [W:0]   out_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic         zero_q, zero_d;
    logic [W:0]   count_q, count_d;

    logic [W-1:0] first_idx;
    logic         single_bit;
    logic [W:0]   in_popcount;
    logic         emitting;

    // Later loop iterations override earlier ones, so the scan direction
    // decides which set bit wins.
    always_comb begin
        first_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pend_q[i]) first_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend_q[i]) first_idx = W'(i);
            end
        end
    end

    always_comb begin
        in_popcount = '0;
        for (int i = 0; i < N; i++) begin
            in_popcount = in_popcount + (W+1)'(in[i]);
        end
    end

    assign single_bit = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);
    assign emitting   = (state_q == EMIT);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = emitting;
    assign out       = (emitting && !zero_q) ? first_idx : '0;
    assign out_last  = emitting && (single_bit || zero_q);
    assign out_zero  = emitting && zero_q;
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zero_d  = zero_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pend_d  = in;
                    count_d = in_popcount;
                    zero_d  = (in == '0);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_d = pend_q & ~(N'(1) << first_idx);
                    if (out_last) begin
                        state_d = IDLE;
                        zero_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zero_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zero_q  <= zero_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Drives an LSB-first and an MSB-first encoder side by side with directed and
// random vectors, comparing every beat against a set-bit list model.
module tb_onehot_serial_encoder;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready_l, out_valid_l, out_last_l, out_zero_l;
    logic [W-1:0] out_l;
    logic [W:0]   out_count_l;
    logic         in_ready_h, out_valid_h, out_last_h, out_zero_h;
    logic [W-1:0] out_h;
    logic [W:0]   out_count_h;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_serial_encoder #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready_l),
        .out(out_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_last(out_last_l), .out_zero(out_zero_l), .out_count(out_count_l)
    );

    onehot_serial_encoder #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready_h),
        .out(out_h), .out_valid(out_valid_h), .out_ready(out_ready),
        .out_last(out_last_h), .out_zero(out_zero_h), .out_count(out_count_h)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid_lsb"}, 32'(out_valid_l), 0);
        checkOutput({tag, "_valid_msb"}, 32'(out_valid_h), 0);
        checkOutput({tag, "_ready_lsb"}, 32'(in_ready_l), 1);
        checkOutput({tag, "_ready_msb"}, 32'(in_ready_h), 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkIdle(tag);
        checkOutput({tag, "_out_lsb"},   32'(out_l), 0);
        checkOutput({tag, "_out_msb"},   32'(out_h), 0);
        checkOutput({tag, "_last_lsb"},  32'(out_last_l), 0);
        checkOutput({tag, "_last_msb"},  32'(out_last_h), 0);
        checkOutput({tag, "_zero_lsb"},  32'(out_zero_l), 0);
        checkOutput({tag, "_zero_msb"},  32'(out_zero_h), 0);
        checkOutput({tag, "_count_lsb"}, 32'(out_count_l), 0);
        checkOutput({tag, "_count_msb"}, 32'(out_count_h), 0);
    endtask

    // Called at a negedge with both encoders idle; returns at the negedge
    // following the final accepted beat.
    task automatic applyStimulus(input logic [N-1:0] vec, input bit randomReady,
                                 input int firstStall, input logic [N-1:0] intruder);
        int  asc[$];
        int  setCount;
        bit  isZero;
        int  beats;
        int  b = 0;
        int  stalls = 0;
        int  consec = 0;
        bit  ready;

        for (int i = 0; i < N; i++) begin
            if (vec[i]) asc.push_back(i);
        end
        setCount = asc.size();
        isZero   = (setCount == 0);
        if (isZero) asc.push_back(0);
        beats = asc.size();

        checkIdle("pre_capture");
        in        = vec;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in       = intruder;
        in_valid = 1'b1;

        while (b < beats) begin
            checkOutput("valid_lsb", 32'(out_valid_l), 1);
            checkOutput("valid_msb", 32'(out_valid_h), 1);
            checkOutput("busy_lsb",  32'(in_ready_l), 0);
            checkOutput("busy_msb",  32'(in_ready_h), 0);
            checkOutput("out_lsb",   32'(out_l), 32'(asc[b]));
            checkOutput("out_msb",   32'(out_h), 32'(asc[beats-1-b]));
            checkOutput("last_lsb",  32'(out_last_l), 32'(b == beats - 1));
            checkOutput("last_msb",  32'(out_last_h), 32'(b == beats - 1));
            checkOutput("zero_lsb",  32'(out_zero_l), 32'(isZero));
            checkOutput("zero_msb",  32'(out_zero_h), 32'(isZero));
            checkOutput("count_lsb", 32'(out_count_l), 32'(setCount));
            checkOutput("count_msb", 32'(out_count_h), 32'(setCount));

            if (b == 0 && stalls < firstStall) begin
                ready = 1'b0;
                stalls++;
            end else if (randomReady && consec < 3 && $urandom_range(0, 3) == 0) begin
                ready = 1'b0;
            end else begin
                ready = 1'b1;
            end
            out_ready = ready;
            if (ready) begin
                b++;
                consec = 0;
            end else begin
                consec++;
            end
            @(negedge clk);
        end

        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkIdle("post_burst");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] junk;

        rst       = 1'b1;
        in        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(8'b1010_0100, 1'b0, 0, 8'h00);
        applyStimulus(8'h00,        1'b0, 0, 8'h00);
        applyStimulus(8'hFF,        1'b0, 3, 8'h18);
        applyStimulus(8'h80,        1'b0, 0, 8'h00);

        // Abort a burst of 8'hF0 after two accepted beats.
        in        = 8'hF0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("abort_beat0_lsb", 32'(out_l), 4);
        checkOutput("abort_beat0_msb", 32'(out_h), 7);
        @(negedge clk);
        checkOutput("abort_beat1_lsb", 32'(out_l), 5);
        checkOutput("abort_beat1_msb", 32'(out_h), 6);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("abort_pending_lsb", 32'(out_valid_l), 1);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkIdle("after_release");
        out_ready = 1'b0;
        applyStimulus(8'b0000_0011, 1'b0, 0, 8'h00);

        for (int n = 0; n < 30; n++) begin
            v    = N'($urandom);
            junk = N'($urandom);
            if ($urandom_range(0, 7) == 0) v = '0;
            applyStimulus(v, 1'b1, $urandom_range(0, 2), junk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
